// File: rtl/ctrl_seq_unit.sv
// Instruction control unit: decodes ALU/memory/branch fields into control words and expands LDM/STM into per-register micro-ops.
// Latency: one cycle from accept to out_valid; one micro-op per cycle during a block transfer.
// Backpressure: out_valid & !out_ready freezes every output; in_ready is low during a burst or while a held word is not consumed.
module ctrl_seq_unit #(
    parameter int CMD_W   = 4,
    parameter int RLIST_W = 16,
    parameter int RIDX_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [1:0]         mode,
    input  logic               s,
    input  logic [RLIST_W-1:0] rlist,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               wb_en,
    output logic               mem_r_en,
    output logic               mem_w_en,
    output logic               branch,
    output logic               s_out,
    output logic [CMD_W-1:0]   exe_cmd,
    output logic [RIDX_W-1:0]  uop_reg,
    output logic [RIDX_W+1:0]  uop_ofs,
    output logic               uop_last,
    output logic               busy
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    localparam logic [RLIST_W-1:0] ONE = {{(RLIST_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_n;
    logic [RLIST_W-1:0]  mask_q, mask_n;
    logic [RIDX_W-1:0]   cnt_q, cnt_n;
    logic                out_valid_q, out_valid_n;
    logic                wb_en_q, wb_en_n;
    logic                mem_r_en_q, mem_r_en_n;
    logic                mem_w_en_q, mem_w_en_n;
    logic                branch_q, branch_n;
    logic                s_out_q, s_out_n;
    logic [CMD_W-1:0]    exe_cmd_q, exe_cmd_n;
    logic [RIDX_W-1:0]   uop_reg_q, uop_reg_n;
    logic                uop_last_q, uop_last_n;

    logic                d_wb, d_mr, d_mw, d_br, d_so;
    logic [3:0]          d_cmd;
    logic [RIDX_W-1:0]   rlist_lsb, mask_lsb;
    logic [RLIST_W-1:0]  rlist_rest, mask_rest;
    logic                accept, advance;

    // Index of the lowest set bit; the downward scan lets the lowest one win.
    function automatic logic [RIDX_W-1:0] lsb_idx(input logic [RLIST_W-1:0] v);
        logic [RIDX_W-1:0] r;
        r = '0;
        for (int i = RLIST_W - 1; i >= 0; i--) begin
            if (v[i]) r = RIDX_W'(i);
        end
        return r;
    endfunction

    assign rlist_lsb  = lsb_idx(rlist);
    assign mask_lsb   = lsb_idx(mask_q);
    assign rlist_rest = rlist & (rlist - ONE);
    assign mask_rest  = mask_q & (mask_q - ONE);

    assign in_ready = (state_q == IDLE) & (~out_valid_q | out_ready) & ~flush;
    assign accept   = in_valid & in_ready;
    assign advance  = out_valid_q & out_ready;

    // Decode the incoming field set into the control flags of its first micro-op.
    always_comb begin
        d_wb  = 1'b0;
        d_mr  = 1'b0;
        d_mw  = 1'b0;
        d_br  = 1'b0;
        d_so  = 1'b0;
        d_cmd = 4'b0000;
        case (mode)
            2'b00: begin
                d_wb = 1'b1;
                d_so = s;
                case (opcode)
                    4'b1101: d_cmd = 4'b0001;
                    4'b1111: d_cmd = 4'b1001;
                    4'b0100: d_cmd = 4'b0010;
                    4'b0101: d_cmd = 4'b0011;
                    4'b0010: d_cmd = 4'b0100;
                    4'b0110: d_cmd = 4'b0101;
                    4'b0000: d_cmd = 4'b0110;
                    4'b1100: d_cmd = 4'b0111;
                    4'b0001: d_cmd = 4'b1000;
                    4'b1010: begin d_cmd = 4'b0100; d_wb = 1'b0; d_so = 1'b1; end
                    4'b1000: begin d_cmd = 4'b0110; d_wb = 1'b0; d_so = 1'b1; end
                    default: begin d_cmd = 4'b0000; d_wb = 1'b0; d_so = 1'b0; end
                endcase
            end
            2'b01: begin
                d_cmd = 4'b0010;
                d_wb  = s;
                d_mr  = s;
                d_so  = s;
                d_mw  = ~s;
            end
            2'b10: d_br = 1'b1;
            default: begin
                // An empty register list becomes a single no-op word.
                if (rlist != '0) begin
                    d_cmd = 4'b0010;
                    d_wb  = s;
                    d_mr  = s;
                    d_mw  = ~s;
                end
            end
        endcase
    end

    // Next state and next control word: flush first, then accept in IDLE, then burst advance.
    always_comb begin
        state_n     = state_q;
        mask_n      = mask_q;
        cnt_n       = cnt_q;
        out_valid_n = out_valid_q;
        wb_en_n     = wb_en_q;
        mem_r_en_n  = mem_r_en_q;
        mem_w_en_n  = mem_w_en_q;
        branch_n    = branch_q;
        s_out_n     = s_out_q;
        exe_cmd_n   = exe_cmd_q;
        uop_reg_n   = uop_reg_q;
        uop_last_n  = uop_last_q;
        if (flush) begin
            out_valid_n = 1'b0;
            mask_n      = '0;
            state_n     = IDLE;
        end else if (state_q == IDLE) begin
            if (accept) begin
                out_valid_n = 1'b1;
                wb_en_n     = d_wb;
                mem_r_en_n  = d_mr;
                mem_w_en_n  = d_mw;
                branch_n    = d_br;
                s_out_n     = d_so;
                exe_cmd_n   = CMD_W'(d_cmd);
                cnt_n       = '0;
                uop_reg_n   = '0;
                uop_last_n  = 1'b1;
                mask_n      = '0;
                if (mode == 2'b11 && rlist != '0) begin
                    uop_reg_n = rlist_lsb;
                    mask_n    = rlist_rest;
                    if (rlist_rest != '0) begin
                        uop_last_n = 1'b0;
                        state_n    = BURST;
                    end
                end
            end else if (advance) begin
                out_valid_n = 1'b0;
            end
        end else if (advance) begin
            // Flags carry over unchanged; only the register, offset and last marker move.
            uop_reg_n  = mask_lsb;
            mask_n     = mask_rest;
            cnt_n      = cnt_q + 1'b1;
            uop_last_n = (mask_rest == '0);
            if (mask_rest == '0) state_n = IDLE;
        end
    end

    // State and output registers; reset aborts any burst immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            wb_en_q     <= 1'b0;
            mem_r_en_q  <= 1'b0;
            mem_w_en_q  <= 1'b0;
            branch_q    <= 1'b0;
            s_out_q     <= 1'b0;
            exe_cmd_q   <= '0;
            uop_reg_q   <= '0;
            uop_last_q  <= 1'b0;
        end else begin
            state_q     <= state_n;
            mask_q      <= mask_n;
            cnt_q       <= cnt_n;
            out_valid_q <= out_valid_n;
            wb_en_q     <= wb_en_n;
            mem_r_en_q  <= mem_r_en_n;
            mem_w_en_q  <= mem_w_en_n;
            branch_q    <= branch_n;
            s_out_q     <= s_out_n;
            exe_cmd_q   <= exe_cmd_n;
            uop_reg_q   <= uop_reg_n;
            uop_last_q  <= uop_last_n;
        end
    end

    assign out_valid = out_valid_q;
    assign wb_en     = wb_en_q;
    assign mem_r_en  = mem_r_en_q;
    assign mem_w_en  = mem_w_en_q;
    assign branch    = branch_q;
    assign s_out     = s_out_q;
    assign exe_cmd   = exe_cmd_q;
    assign uop_reg   = uop_reg_q;
    assign uop_ofs   = {cnt_q, 2'b00};
    assign uop_last  = uop_last_q;
    assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// Directed bench for ctrl_seq_unit: decode table, block-transfer expansion, stall, flush and reset.
// Inputs change and outputs are sampled on the falling clock edge.
// Downstream readiness is driven per scenario to exercise output hold.
module tb_ctrl_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [1:0]  mode;
    logic        s;
    logic [15:0] rlist;
    logic        out_valid;
    logic        out_ready;
    logic        wb_en, mem_r_en, mem_w_en, branch, s_out;
    logic [3:0]  exe_cmd;
    logic [3:0]  uop_reg;
    logic [5:0]  uop_ofs;
    logic        uop_last;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [21:0] exp_w;
    logic [21:0] obs;

    ctrl_seq_unit #(.CMD_W(4), .RLIST_W(16), .RIDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .mode(mode), .s(s), .rlist(rlist),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .branch(branch), .s_out(s_out), .exe_cmd(exe_cmd),
        .uop_reg(uop_reg), .uop_ofs(uop_ofs), .uop_last(uop_last), .busy(busy)
    );

    always #5 clk = ~clk;

    assign obs = {out_valid, wb_en, mem_r_en, mem_w_en, branch, s_out, uop_last, busy,
                  exe_cmd, uop_reg, uop_ofs};

    function automatic logic [21:0] w(input logic v, input logic wb, input logic mr,
                                      input logic mw, input logic br, input logic so,
                                      input logic last, input logic bsy, input logic [3:0] cmd,
                                      input logic [3:0] r, input logic [5:0] ofs);
        return {v, wb, mr, mw, br, so, last, bsy, cmd, r, ofs};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [1:0] md, input logic sb,
                         input logic [15:0] rl);
        in_valid = 1'b1;
        opcode   = op;
        mode     = md;
        s        = sb;
        rlist    = rl;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(4'b0100, 2'b00, 1'b1, 16'h0000);
        repeat (2) @(negedge clk);
        exp_w = '0;
        checks++; if (obs !== exp_w) begin errors++; $display("FAIL reset_outputs got=%h want=%h", obs, exp_w); end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_alu_b2b;
        @(negedge clk); drive(4'b0100, 2'b00, 1'b1, 16'h0);
        @(negedge clk);
        exp_w = w(1,1,0,0,0,1,1,0,4'b0010,4'd0,6'd0);
        checks++; if (obs !== exp_w) begin errors++; $display("FAIL add_word got=%h want=%h", obs, exp_w); end
        drive(4'b1010, 2'b00, 1'b0, 16'h0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        exp_w = w(1,0,0,0,0,1,1,0,4'b0100,4'd0,6'd0);
        checks++; if (obs !== exp_w) begin errors++; $display("FAIL cmp_word got=%h want=%h", obs, exp_w); end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alu_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_decode;
        logic [6:0]  stim [13];
        logic [21:0] ex   [13];
        stim[0]  = {4'b1101, 2'b00, 1'b0}; ex[0]  = w(1,1,0,0,0,0,1,0,4'b0001,0,0);
        stim[1]  = {4'b1111, 2'b00, 1'b1}; ex[1]  = w(1,1,0,0,0,1,1,0,4'b1001,0,0);
        stim[2]  = {4'b0101, 2'b00, 1'b0}; ex[2]  = w(1,1,0,0,0,0,1,0,4'b0011,0,0);
        stim[3]  = {4'b0010, 2'b00, 1'b0}; ex[3]  = w(1,1,0,0,0,0,1,0,4'b0100,0,0);
        stim[4]  = {4'b0110, 2'b00, 1'b1}; ex[4]  = w(1,1,0,0,0,1,1,0,4'b0101,0,0);
        stim[5]  = {4'b0000, 2'b00, 1'b0}; ex[5]  = w(1,1,0,0,0,0,1,0,4'b0110,0,0);
        stim[6]  = {4'b1100, 2'b00, 1'b0}; ex[6]  = w(1,1,0,0,0,0,1,0,4'b0111,0,0);
        stim[7]  = {4'b0001, 2'b00, 1'b0}; ex[7]  = w(1,1,0,0,0,0,1,0,4'b1000,0,0);
        stim[8]  = {4'b1000, 2'b00, 1'b0}; ex[8]  = w(1,0,0,0,0,1,1,0,4'b0110,0,0);
        stim[9]  = {4'b0011, 2'b00, 1'b1}; ex[9]  = w(1,0,0,0,0,0,1,0,4'b0000,0,0);
        stim[10] = {4'b0000, 2'b01, 1'b1}; ex[10] = w(1,1,1,0,0,1,1,0,4'b0010,0,0);
        stim[11] = {4'b0100, 2'b01, 1'b0}; ex[11] = w(1,0,0,1,0,0,1,0,4'b0010,0,0);
        stim[12] = {4'b0100, 2'b10, 1'b1}; ex[12] = w(1,0,0,0,1,0,1,0,4'b0000,0,0);
        for (int i = 0; i <= 13; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (obs !== ex[i-1]) begin errors++; $display("FAIL decode_%0d got=%h want=%h", i-1, obs, ex[i-1]); end
            end
            if (i < 13) drive(stim[i][6:3], stim[i][2:1], stim[i][0], 16'h0);
            else in_valid = 1'b0;
        end
    endtask

    task automatic test_ldm;
        @(negedge clk); drive(4'b0000, 2'b11, 1'b1, 16'h8011);
        @(negedge clk); in_valid = 1'b0;
        exp_w = w(1,1,1,0,0,0,0,1,4'b0010,4'd0,6'd0);
        checks++; if (obs !== exp_w) begin errors++; $display("FAIL ldm_uop0 got=%h want=%h", obs, exp_w); end
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ldm_ready0 got=%b want=0", in_ready); end
        @(negedge clk);
        exp_w = w(1,1,1,0,0,0,0,1,4'b0010,4'd4,6'd4);
        checks++; if (obs !== exp_w) begin errors++; $display("FAIL ldm_uop1 got=%h want=%h", obs, exp_w); end
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ldm_ready1 got=%b want=0", in_ready); end
        @(negedge clk);
        exp_w = w(1,1,1,0,0,0,1,0,4'b0010,4'd15,6'd8);
        checks++; if (obs !== exp_w) begin errors++; $display("FAIL ldm_uop2 got=%h want=%h", obs, exp_w); end
        drive(4'b0100, 2'b00, 1'b0, 16'h0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ldm_ready_last got=%b want=1", in_ready); end
        @(negedge clk); in_valid = 1'b0;
        exp_w = w(1,1,0,0,0,0,1,0,4'b0010,4'd0,6'd0);
        checks++; if (obs !== exp_w) begin errors++; $display("FAIL ldm_follow got=%h want=%h", obs, exp_w); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ldm_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_stm_backpressure;
        @(negedge clk); drive(4'b0000, 2'b11, 1'b0, 16'h0006);
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
        exp_w = w(1,0,0,1,0,0,0,1,4'b0010,4'd1,6'd0);
        checks++; if (obs !== exp_w) begin errors++; $display("FAIL stm_uop0 got=%h want=%h", obs, exp_w); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (obs !== exp_w) begin errors++; $display("FAIL stm_hold_%0d got=%h want=%h", k, obs, exp_w); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        exp_w = w(1,0,0,1,0,0,1,0,4'b0010,4'd2,6'd4);
        checks++; if (obs !== exp_w) begin errors++; $display("FAIL stm_uop1 got=%h want=%h", obs, exp_w); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stm_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_flush;
        @(negedge clk); drive(4'b0000, 2'b11, 1'b1, 16'h00F0);
        @(negedge clk); in_valid = 1'b0;
        exp_w = w(1,1,1,0,0,0,0,1,4'b0010,4'd4,6'd0);
        checks++; if (obs !== exp_w) begin errors++; $display("FAIL flush_uop0 got=%h want=%h", obs, exp_w); end
        @(negedge clk);
        exp_w = w(1,1,1,0,0,0,0,1,4'b0010,4'd5,6'd4);
        checks++; if (obs !== exp_w) begin errors++; $display("FAIL flush_uop1 got=%h want=%h", obs, exp_w); end
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
        @(negedge clk); flush = 1'b0;
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL flush_kill got=%b want=00", {out_valid, busy}); end
        drive(4'b1101, 2'b00, 1'b1, 16'h0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_ready got=%b want=1", in_ready); end
        @(negedge clk); in_valid = 1'b0;
        exp_w = w(1,1,0,0,0,1,1,0,4'b0001,4'd0,6'd0);
        checks++; if (obs !== exp_w) begin errors++; $display("FAIL flush_next got=%h want=%h", obs, exp_w); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_resume got=%b want=0", out_valid); end
    endtask

    task automatic test_empty_and_reset;
        @(negedge clk); drive(4'b0000, 2'b11, 1'b1, 16'h0000);
        @(negedge clk); in_valid = 1'b0;
        exp_w = w(1,0,0,0,0,0,1,0,4'b0000,4'd0,6'd0);
        checks++; if (obs !== exp_w) begin errors++; $display("FAIL empty_rlist got=%h want=%h", obs, exp_w); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_drain got=%b want=0", out_valid); end
        drive(4'b0000, 2'b11, 1'b1, 16'h000F);
        @(negedge clk); in_valid = 1'b0;
        exp_w = w(1,1,1,0,0,0,0,1,4'b0010,4'd0,6'd0);
        checks++; if (obs !== exp_w) begin errors++; $display("FAIL rst_burst_uop0 got=%h want=%h", obs, exp_w); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (obs !== 22'h0) begin errors++; $display("FAIL async_reset got=%h want=0", obs); end
        @(negedge clk); rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b want=1", in_ready); end
        @(negedge clk);
        checks++; if (obs !== 22'h0) begin errors++; $display("FAIL post_reset_no_resume got=%h want=0", obs); end
    endtask

    initial begin
        test_reset();
        test_alu_b2b();
        test_decode();
        test_ldm();
        test_stm_backpressure();
        test_flush();
        test_empty_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_seq_unit.md
# ctrl_seq_unit

Parametrised, registered instruction control unit with micro-op sequencing. Accepts one decoded instruction field set (opcode, mode, S, register list) per handshake and emits registered control words for the execute stage. Single-cycle ALU, memory and branch instructions produce one micro-op. A new block-transfer mode (LDM/STM) is expanded into one micro-op per set register-list bit. Sits between instruction decode and the ID/EX pipeline register, with valid/ready on both sides and a synchronous flush for branch redirection.

## Interface
- CMD_W, 4, exe_cmd width (>=4; 4-bit codes zero-extended)
- RLIST_W, 16, register-list width (power of two)
- RIDX_W, 4, log2(RLIST_W)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of held output and any burst in progress
- in_valid  in  1  instruction fields valid
- in_ready  out  1  unit accepts this cycle
- opcode  in  4  ALU opcode
- mode  in  2  00 ALU, 01 single memory, 10 branch, 11 block transfer
- s  in  1  S bit (L bit for modes 01/11)
- rlist  in  RLIST_W  register list (mode 11 only)
- out_valid  out  1  control word valid
- out_ready  in  1  downstream consumes
- wb_en, mem_r_en, mem_w_en, branch, s_out  out  1 each  control flags
- exe_cmd  out  CMD_W  ALU command
- uop_reg  out  RIDX_W  register index of micro-op (0 for non-block)
- uop_ofs  out  RIDX_W+2  byte offset, 4*micro-op index
- uop_last  out  1  final micro-op of instruction
- busy  out  1  burst in progress

## Operation
- Mode 00 decode: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000; wb_en=1, s_out=s. CMP 1010->0100, TST 1000->0110, wb_en=0, s_out=1. Other opcodes: all flags 0, exe_cmd 0.
- Mode 01: s=1 LDR (wb_en, mem_r_en, s_out=1, exe_cmd 0010); s=0 STR (mem_w_en, exe_cmd 0010).
- Mode 10: branch=1, rest 0.
- Mode 11: s=1 LDM micro-ops wb_en=1, mem_r_en=1; s=0 STM micro-ops mem_w_en=1; exe_cmd 0010, s_out=0. Registers emitted in ascending index order; k-th micro-op: uop_reg=index of k-th set bit, uop_ofs=4*k. rlist=0: one micro-op, all flags 0, uop_last=1.
- FSM IDLE/BURST. in_ready = IDLE & (!out_valid | out_ready) & !flush.
- IDLE accept: load first micro-op; remaining mask = rlist minus lowest set bit; remaining nonzero -> BURST, uop_last=0; else uop_last=1.
- BURST: on out_valid & out_ready load next lowest set bit, clear it; uop_last=1 when mask becomes 0, then IDLE after that micro-op loads. busy=1 in BURST.
- Backpressure: out_valid=1 & out_ready=0 holds every output stable.
- flush: next edge out_valid=0, mask cleared, state IDLE; wins over simultaneous accept and advance.

## Timing
- Reset: out_valid=0, all flags 0, exe_cmd 0, uop_reg 0, uop_ofs 0, uop_last 0, busy 0, IDLE; in_ready=1 once out of reset.
- Latency 1: accepted at edge N, out_valid visible after edge N.
- Throughput: 1 single-uop instruction/cycle with out_ready=1; N-bit block occupies N cycles, next instruction accepted in cycle of last micro-op's consumption.
- Reset mid-burst aborts immediately; no micro-op resumes.

## Test plan
- Reset with in_valid=1 -> all outputs 0, out_valid=0; after release in_ready=1.
- ADD s=1 then CMP s=0, out_ready=1 -> back-to-back words exe_cmd 0010 wb_en=1 s_out=1, then 0100 wb_en=0 s_out=1, uop_last=1.
- LDM rlist=0x8011 -> three words uop_reg 0/4/15, uop_ofs 0/4/8, wb_en=mem_r_en=1, uop_last only on third, in_ready=0 during first two.
- STM rlist=0x0006 with out_ready low 3 cycles on first word -> outputs frozen, then reg 1 ofs 0, reg 2 ofs 4, mem_w_en=1.
- Flush after second of four-register burst -> out_valid=0 next cycle, IDLE, following instruction decoded normally.
- Block rlist=0 -> single no-op word uop_last=1; reset asserted mid-burst -> outputs 0 asynchronously.
